multicycle_cpu: RTL and testbench
=================================

Name: multicycle_cpu

Overview:
- Parametrised multi-cycle successor to the single-cycle 16-bit teaching CPU.
- One shared ALU; an FSM sequences FETCH/DECODE/EXEC/MEM/WB per instruction.
- Instruction and data memory are external, each behind a req/ready handshake, so wait-state memories attach directly.
- Debug read port, state and retired-instruction counter exposed for the bench; the core stops in HALTED on a HALT opcode.

Parameters:
- DATA_W, 16, register/ALU/data width (>=16)
- PC_W, 16, PC and imem address width (>=12)
- DMEM_AW, 16, dmem address width; low DMEM_AW bits of ALU result
- RESET_PC, 0, PC value loaded at reset

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  synchronous, active-high reset
- imem_req  out  1  fetch request
- imem_addr  out  PC_W  fetch word address (= pc)
- imem_rdata  in  16  instruction word
- imem_ready  in  1  fetch completes this cycle
- dmem_req  out  1  data access request
- dmem_we  out  1  1 = store, 0 = load
- dmem_addr  out  DMEM_AW  data word address
- dmem_wdata  out  DATA_W  store data
- dmem_rdata  in  DATA_W  load data
- dmem_ready  in  1  data access completes this cycle
- dbg_raddr  in  4  debug register select
- dbg_rdata  out  DATA_W  combinational read of register dbg_raddr
- pc  out  PC_W  current PC
- ir  out  16  latched instruction
- state  out  3  FSM state encoding
- halted  out  1  core in HALTED
- instr_cnt  out  32  retired instructions

Behaviour:
- ISA fields: op[15:12], rs[11:8], rt[7:4], rd/imm4[3:0]. 16 registers; r0 reads 0, writes to it are dropped. imm4 is sign-extended.
- Opcodes:
  - 0 ADD, 1 SUB, 2 AND, 3 OR: rd = rs op rt
  - 4 SLT: signed compare, rd = 1 or 0
  - 5 ADDI: rt = rs + imm
  - 6 LW: rt = mem[rs + imm]
  - 7 SW: mem[rs + imm] = rt
  - 8 BEQ: if rs == rt, pc = pc + 1 + imm
  - 9 J: pc = zero-extended ir[11:0]
  - F HALT
  - A–E: NOP
- Arithmetic wraps modulo 2^DATA_W. PC arithmetic wraps modulo 2^PC_W.
- Reset (rst high at an edge):
  - state = FETCH, pc = RESET_PC, all registers = 0, ir = 0, instr_cnt = 0, halted = 0
  - imem_req = dmem_req = dmem_we = 0 while rst is high
  - Any in-flight transaction is abandoned, no register/PC side effects.
- FETCH:
  - imem_req = 1, imem_addr = pc, held stable until imem_ready.
  - On the edge where imem_ready = 1: ir <= imem_rdata, pc <= pc + 1, go to DECODE.
  - Zero-wait memory (ready in the same cycle as req) is legal.
- DECODE: latch A = R[rs], B = R[rt] -> EXEC.
- EXEC:
  - ALU op. BEQ/J update pc -> FETCH.
  - NOP -> FETCH.
  - R-type/ADDI -> WB.
  - LW/SW -> MEM.
  - HALT -> HALTED.
- MEM:
  - dmem_req = 1, dmem_we = (SW), dmem_addr/dmem_wdata held stable until dmem_ready.
  - SW -> FETCH.
  - LW latches dmem_rdata -> WB.
- WB: write the destination register -> FETCH.
- HALTED: terminal; no requests issued, halted = 1; exit only via rst.
- instr_cnt increments by 1 on the final cycle of every non-HALT instruction (WB, MEM of SW, EXEC of BEQ/J/NOP).
- Latency with zero-wait memories:
  - ALU/ADDI: 4 cycles
  - LW: 5 cycles
  - SW: 4 cycles
  - BEQ/J/NOP: 3 cycles
  - HALT reached 3 cycles after its fetch begins
- Each wait cycle adds exactly 1 cycle.
- dbg_rdata is combinational; it reflects a WB write from the next cycle.

Decomposition:
- Package cpu_pkg: opcode constants, FSM state enum (FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, HALTED=5), ALU-op enum, field-slice constants.
- One sub-module: regfile_2r1w (16 x DATA_W, two async read ports plus debug read, one sync write, r0 forced zero, sync reset clear).

Test Plan:
- Zero-wait program: ADDI r1,r0,5; ADDI r2,r0,3; ADD r3,r1,r2; HALT -> r3 = 8, halted = 1 at cycle 15 after reset release, instr_cnt = 3.
- SW r3,2(r0) then LW r4,2(r0) with r3 = 8 -> one dmem write (addr 2, wdata 8, we = 1); then a read of addr 2; r4 = 8; SW takes 4 cycles, LW takes 5.
- BEQ branch targets:
  - BEQ r1,r1,+2 at pc 4 -> next fetch addr 7.
  - BEQ r1,r2,+2 with r1 = 5, r2 = 3 -> next fetch addr 5.
  - J 0x00A -> next fetch addr 10.
- Wait states: imem_ready low 3 cycles -> imem_req and imem_addr stable, pc unchanged, instruction takes 7 cycles. Same check on dmem_ready for LW.
- Edge arithmetic, DATA_W = 16:
  - SUB r1,r0,r5 with r5 = 1 -> 0xFFFF
  - SLT r2,r1,r5 -> 1
  - ADDI r0,r0,7 -> dbg r0 reads 0
- Reset while in MEM with dmem_ready low -> next cycle dmem_req = 0, pc = RESET_PC, state = FETCH, all registers 0, no write occurs.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared definitions for the multi-cycle CPU: opcodes, FSM states, ALU ops
// and instruction field positions.
package cpu_pkg;

  // Opcodes (instruction bits [15:12])
  localparam logic [3:0] OP_ADD  = 4'h0;
  localparam logic [3:0] OP_SUB  = 4'h1;
  localparam logic [3:0] OP_AND  = 4'h2;
  localparam logic [3:0] OP_OR   = 4'h3;
  localparam logic [3:0] OP_SLT  = 4'h4;
  localparam logic [3:0] OP_ADDI = 4'h5;
  localparam logic [3:0] OP_LW   = 4'h6;
  localparam logic [3:0] OP_SW   = 4'h7;
  localparam logic [3:0] OP_BEQ  = 4'h8;
  localparam logic [3:0] OP_J    = 4'h9;
  localparam logic [3:0] OP_HALT = 4'hF;

  // Instruction field slices
  localparam int OP_MSB = 15;
  localparam int OP_LSB = 12;
  localparam int RS_MSB = 11;
  localparam int RS_LSB = 8;
  localparam int RT_MSB = 7;
  localparam int RT_LSB = 4;
  localparam int RD_MSB = 3;
  localparam int RD_LSB = 0;

  // FSM states; the encoding is visible on the state output
  typedef enum logic [2:0] {
    ST_FETCH  = 3'd0,
    ST_DECODE = 3'd1,
    ST_EXEC   = 3'd2,
    ST_MEM    = 3'd3,
    ST_WB     = 3'd4,
    ST_HALTED = 3'd5
  } state_t;

  typedef enum logic [2:0] {
    ALU_ADD = 3'd0,
    ALU_SUB = 3'd1,
    ALU_AND = 3'd2,
    ALU_OR  = 3'd3,
    ALU_SLT = 3'd4
  } alu_op_t;

  // Loads, stores and ADDI reuse the adder for address / immediate sums.
  function automatic alu_op_t alu_op_of(input logic [3:0] op);
    case (op)
      OP_SUB:  return ALU_SUB;
      OP_AND:  return ALU_AND;
      OP_OR:   return ALU_OR;
      OP_SLT:  return ALU_SLT;
      default: return ALU_ADD;
    endcase
  endfunction

endpackage

// File: rtl/multicycle_cpu_regfile.sv
// 16-entry register file: two async read ports, one debug read port,
// one synchronous write port. r0 always reads zero.
module regfile_2r1w
  import cpu_pkg::*;
#(
  parameter int DATA_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [3:0]        i_ra1,
  input  logic [3:0]        i_ra2,
  input  logic [3:0]        i_dbg_ra,
  output logic [DATA_W-1:0] o_rd1,
  output logic [DATA_W-1:0] o_rd2,
  output logic [DATA_W-1:0] o_dbg_rd,
  input  logic              i_we,
  input  logic [3:0]        i_wa,
  input  logic [DATA_W-1:0] i_wd
);

  logic [DATA_W-1:0] r_mem [16];

  // Clear on reset; writes to r0 are discarded so it stays zero
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 16; i++) r_mem[i] <= '0;
    end else if (i_we && (i_wa != 4'd0)) begin
      r_mem[i_wa] <= i_wd;
    end
  end

  // Combinational reads with r0 forced to zero
  always_comb begin
    o_rd1    = (i_ra1    == 4'd0) ? '0 : r_mem[i_ra1];
    o_rd2    = (i_ra2    == 4'd0) ? '0 : r_mem[i_ra2];
    o_dbg_rd = (i_dbg_ra == 4'd0) ? '0 : r_mem[i_dbg_ra];
  end

endmodule

// File: rtl/multicycle_cpu.sv
// Multi-cycle 16-bit-ISA CPU. One FSM walks FETCH/DECODE/EXEC/MEM/WB;
// instruction and data memories sit behind req/ready handshakes.
//
// Handshake: req is a pure function of state and stays high (with address
// and data held in registers, hence stable) until the cycle in which ready
// is sampled high at the clock edge; that edge completes the transfer.
// ready without req is ignored. Both reqs are forced low while rst is high.
module multicycle_cpu
  import cpu_pkg::*;
#(
  parameter int              DATA_W   = 16,
  parameter int              PC_W     = 16,
  parameter int              DMEM_AW  = 16,
  parameter logic [PC_W-1:0] RESET_PC = '0
) (
  input  logic               clk,
  input  logic               rst,
  output logic               imem_req,
  output logic [PC_W-1:0]    imem_addr,
  input  logic [15:0]        imem_rdata,
  input  logic               imem_ready,
  output logic               dmem_req,
  output logic               dmem_we,
  output logic [DMEM_AW-1:0] dmem_addr,
  output logic [DATA_W-1:0]  dmem_wdata,
  input  logic [DATA_W-1:0]  dmem_rdata,
  input  logic               dmem_ready,
  input  logic [3:0]         dbg_raddr,
  output logic [DATA_W-1:0]  dbg_rdata,
  output logic [PC_W-1:0]    pc,
  output logic [15:0]        ir,
  output logic [2:0]         state,
  output logic               halted,
  output logic [31:0]        instr_cnt
);

  state_t            r_state;
  logic [PC_W-1:0]   r_pc;
  logic [15:0]       r_ir;
  logic [DATA_W-1:0] r_a;
  logic [DATA_W-1:0] r_b;
  logic [DATA_W-1:0] r_res;   // ALU result, then load data for LW
  logic [31:0]       r_cnt;

  logic [3:0]        w_op;
  logic [3:0]        w_rs;
  logic [3:0]        w_rt;
  logic [3:0]        w_rd;
  logic              w_is_rtype;
  logic [DATA_W-1:0] w_imm_d;
  logic [PC_W-1:0]   w_imm_pc;
  logic [DATA_W-1:0] w_rs_data;
  logic [DATA_W-1:0] w_rt_data;
  logic [DATA_W-1:0] w_alu_b;
  logic [DATA_W-1:0] w_alu_res;
  alu_op_t           w_alu_op;
  logic              w_wb_we;
  logic [3:0]        w_wb_addr;

  assign w_op       = r_ir[OP_MSB:OP_LSB];
  assign w_rs       = r_ir[RS_MSB:RS_LSB];
  assign w_rt       = r_ir[RT_MSB:RT_LSB];
  assign w_rd       = r_ir[RD_MSB:RD_LSB];
  assign w_is_rtype = (w_op <= OP_SLT);
  assign w_imm_d    = DATA_W'($signed(r_ir[RD_MSB:RD_LSB]));
  assign w_imm_pc   = PC_W'($signed(r_ir[RD_MSB:RD_LSB]));
  assign w_alu_op   = alu_op_of(w_op);
  assign w_alu_b    = w_is_rtype ? r_b : w_imm_d;

  // R-type writes rd; ADDI and LW write rt
  assign w_wb_we    = (r_state == ST_WB);
  assign w_wb_addr  = w_is_rtype ? w_rd : w_rt;

  regfile_2r1w #(.DATA_W(DATA_W)) u_regfile (
    .clk      (clk),
    .rst      (rst),
    .i_ra1    (w_rs),
    .i_ra2    (w_rt),
    .i_dbg_ra (dbg_raddr),
    .o_rd1    (w_rs_data),
    .o_rd2    (w_rt_data),
    .o_dbg_rd (dbg_rdata),
    .i_we     (w_wb_we),
    .i_wa     (w_wb_addr),
    .i_wd     (r_res)
  );

  // Shared ALU operating on the latched operands
  always_comb begin
    w_alu_res = '0;
    unique case (w_alu_op)
      ALU_ADD: w_alu_res = r_a + w_alu_b;
      ALU_SUB: w_alu_res = r_a - w_alu_b;
      ALU_AND: w_alu_res = r_a & w_alu_b;
      ALU_OR:  w_alu_res = r_a | w_alu_b;
      ALU_SLT: w_alu_res = {{(DATA_W-1){1'b0}}, ($signed(r_a) < $signed(w_alu_b))};
      default: w_alu_res = '0;
    endcase
  end

  // Instruction sequencer; pc already points past the instruction in EXEC
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_FETCH;
      r_pc    <= RESET_PC;
      r_ir    <= '0;
      r_a     <= '0;
      r_b     <= '0;
      r_res   <= '0;
      r_cnt   <= '0;
    end else begin
      case (r_state)
        ST_FETCH: begin
          if (imem_ready) begin
            r_ir    <= imem_rdata;
            r_pc    <= r_pc + PC_W'(1);
            r_state <= ST_DECODE;
          end
        end
        ST_DECODE: begin
          r_a     <= w_rs_data;
          r_b     <= w_rt_data;
          r_state <= ST_EXEC;
        end
        ST_EXEC: begin
          case (w_op)
            OP_ADD, OP_SUB, OP_AND, OP_OR, OP_SLT, OP_ADDI: begin
              r_res   <= w_alu_res;
              r_state <= ST_WB;
            end
            OP_LW, OP_SW: begin
              r_res   <= w_alu_res;
              r_state <= ST_MEM;
            end
            OP_BEQ: begin
              if (r_a == r_b) r_pc <= r_pc + w_imm_pc;
              r_cnt   <= r_cnt + 32'd1;
              r_state <= ST_FETCH;
            end
            OP_J: begin
              r_pc    <= PC_W'(r_ir[RS_MSB:RD_LSB]);
              r_cnt   <= r_cnt + 32'd1;
              r_state <= ST_FETCH;
            end
            OP_HALT: begin
              r_state <= ST_HALTED;
            end
            default: begin
              r_cnt   <= r_cnt + 32'd1;
              r_state <= ST_FETCH;
            end
          endcase
        end
        ST_MEM: begin
          if (dmem_ready) begin
            if (w_op == OP_SW) begin
              r_cnt   <= r_cnt + 32'd1;
              r_state <= ST_FETCH;
            end else begin
              r_res   <= dmem_rdata;
              r_state <= ST_WB;
            end
          end
        end
        ST_WB: begin
          r_cnt   <= r_cnt + 32'd1;
          r_state <= ST_FETCH;
        end
        ST_HALTED: begin
          r_state <= ST_HALTED;
        end
        default: begin
          r_state <= ST_FETCH;
        end
      endcase
    end
  end

  // Memory requests follow the state; reset masks them immediately
  always_comb begin
    imem_req   = !rst && (r_state == ST_FETCH);
    imem_addr  = r_pc;
    dmem_req   = !rst && (r_state == ST_MEM);
    dmem_we    = dmem_req && (w_op == OP_SW);
    dmem_addr  = r_res[DMEM_AW-1:0];
    dmem_wdata = r_b;
  end

  assign pc        = r_pc;
  assign ir        = r_ir;
  assign state     = r_state;
  assign halted    = (r_state == ST_HALTED);
  assign instr_cnt = r_cnt;

endmodule

// File: tb/tb_multicycle_cpu.sv
// Bench for multicycle_cpu: directed programs from the test plan, then
// random programs checked against an instruction-level ISA model.
module tb_multicycle_cpu;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        imem_req;
  logic [15:0] imem_addr;
  logic [15:0] imem_rdata = '0;
  logic        imem_ready = 1'b0;
  logic        dmem_req;
  logic        dmem_we;
  logic [15:0] dmem_addr;
  logic [15:0] dmem_wdata;
  logic [15:0] dmem_rdata = '0;
  logic        dmem_ready = 1'b0;
  logic [3:0]  dbg_raddr = '0;
  logic [15:0] dbg_rdata;
  logic [15:0] pc;
  logic [15:0] ir;
  logic [2:0]  state;
  logic        halted;
  logic [31:0] instr_cnt;

  multicycle_cpu dut (
    .clk(clk), .rst(rst),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_rdata(imem_rdata), .imem_ready(imem_ready),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
    .dmem_rdata(dmem_rdata), .dmem_ready(dmem_ready),
    .dbg_raddr(dbg_raddr), .dbg_rdata(dbg_rdata),
    .pc(pc), .ir(ir), .state(state), .halted(halted), .instr_cnt(instr_cnt)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- bookkeeping ----------------
  int n_cmp = 0;
  int n_err = 0;

  logic [15:0] imem [256];
  logic [15:0] dmem [256];

  int i_lo = 0, i_hi = 0, d_lo = 0, d_hi = 0;
  int i_busy = 0, i_left = 0, d_busy = 0, d_left = 0;
  logic [15:0] i_hold, d_hold_a, d_hold_d;
  logic        d_hold_we;
  int waits = 0;
  int cyc_cnt = 0;

  logic [15:0] fetch_q[$];
  int          fetch_t_q[$];
  logic [31:0] st_q[$];
  logic [15:0] ld_q[$];

  // ---------------- reference model state ----------------
  logic [15:0] mr [16];
  logic [15:0] mdm [256];
  logic [15:0] exp_fetch_q[$];
  logic [31:0] exp_q[$];
  int exp_cyc, exp_cnt;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock: act as both memories at the negedge, then step past posedge.
  task automatic cyc();
    @(negedge clk);
    if (imem_req) begin
      if (i_busy == 0) begin
        i_busy = 1; i_left = $urandom_range(i_hi, i_lo); i_hold = imem_addr;
      end else begin
        chk("imem_addr_stable", imem_addr, i_hold);
        chk("pc_stable", pc, i_hold);
      end
      if (i_left == 0) begin
        imem_ready = 1'b1;
        imem_rdata = imem[imem_addr[7:0]];
        fetch_q.push_back(imem_addr);
        fetch_t_q.push_back(cyc_cnt);
        i_busy = 0;
      end else begin
        imem_ready = 1'b0; imem_rdata = 16'($urandom); i_left--; waits++;
      end
    end else begin
      imem_ready = 1'b0; i_busy = 0;
    end
    if (dmem_req) begin
      if (d_busy == 0) begin
        d_busy = 1; d_left = $urandom_range(d_hi, d_lo);
        d_hold_a = dmem_addr; d_hold_d = dmem_wdata; d_hold_we = dmem_we;
      end else begin
        chk("dmem_addr_stable", dmem_addr, d_hold_a);
        chk("dmem_we_stable", dmem_we, d_hold_we);
        if (d_hold_we) chk("dmem_wdata_stable", dmem_wdata, d_hold_d);
      end
      if (d_left == 0) begin
        dmem_ready = 1'b1;
        if (dmem_we) begin
          dmem[dmem_addr[7:0]] = dmem_wdata;
          st_q.push_back({dmem_addr, dmem_wdata});
        end else begin
          dmem_rdata = dmem[dmem_addr[7:0]];
          ld_q.push_back(dmem_addr);
        end
        d_busy = 0;
      end else begin
        dmem_ready = 1'b0; dmem_rdata = 16'($urandom); d_left--; waits++;
      end
    end else begin
      dmem_ready = 1'b0; d_busy = 0;
    end
    @(posedge clk);
    #1;
    cyc_cnt++;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    cyc();
    cyc();
    rst = 1'b0;
    fetch_q.delete(); fetch_t_q.delete(); st_q.delete(); ld_q.delete();
    waits = 0; cyc_cnt = 0; i_busy = 0; d_busy = 0;
  endtask

  task automatic clear_imem();
    for (int i = 0; i < 256; i++) imem[i] = 16'hF000;
  endtask

  // Run until HALTED or budget; returns cycles since reset release.
  task automatic run_prog(input int max, output int ncyc);
    ncyc = 0;
    while (!halted && ncyc < max) begin
      cyc();
      ncyc++;
    end
    chk("halted_reached", halted, 1'b1);
  endtask

  task automatic chk_reg(input int idx, input logic [15:0] exp, input string tag);
    dbg_raddr = 4'(idx);
    #1;
    chk(tag, dbg_rdata, exp);
  endtask

  // ---------------- ISA-level reference model ----------------
  function automatic void put(input logic [3:0] r, input logic [15:0] v);
    if (r != 4'd0) mr[r] = v;
  endfunction

  task automatic model_run();
    logic [15:0] pcm, w, a, b, simm, ea;
    logic [3:0]  op, rs, rt, rd;
    bit          done;
    for (int i = 0; i < 16; i++) mr[i] = '0;
    for (int i = 0; i < 256; i++) mdm[i] = dmem[i];
    exp_fetch_q.delete(); exp_q.delete();
    exp_cyc = 0; exp_cnt = 0; pcm = '0; done = 0;
    for (int step = 0; step < 400 && !done; step++) begin
      w = imem[pcm[7:0]];
      exp_fetch_q.push_back(pcm);
      pcm = pcm + 16'd1;
      op = w[15:12]; rs = w[11:8]; rt = w[7:4]; rd = w[3:0];
      a = mr[rs]; b = mr[rt];
      simm = {{12{w[3]}}, w[3:0]};
      case (op)
        4'h0: put(rd, a + b);
        4'h1: put(rd, a - b);
        4'h2: put(rd, a & b);
        4'h3: put(rd, a | b);
        4'h4: put(rd, ($signed(a) < $signed(b)) ? 16'd1 : 16'd0);
        4'h5: put(rt, a + simm);
        4'h6: begin ea = a + simm; put(rt, mdm[ea[7:0]]); end
        4'h7: begin ea = a + simm; mdm[ea[7:0]] = b; exp_q.push_back({ea, b}); end
        4'h8: if (a == b) pcm = pcm + simm;
        4'h9: pcm = {4'h0, w[11:0]};
        4'hF: done = 1;
        default: ;
      endcase
      // Zero-wait latency per instruction class
      if (op <= 4'h5)      exp_cyc += 4;
      else if (op == 4'h6) exp_cyc += 5;
      else if (op == 4'h7) exp_cyc += 4;
      else                 exp_cyc += 3;
      if (op != 4'hF) exp_cnt++;
    end
  endtask

  // Random program: forward-only control flow so it always reaches HALT.
  task automatic gen_prog(input int n);
    int kind;
    logic [3:0] a4, b4, c4;
    clear_imem();
    for (int i = 0; i < 256; i++) dmem[i] = 16'($urandom);
    for (int k = 0; k < n; k++) begin
      kind = $urandom_range(10, 0);
      a4 = 4'($urandom); b4 = 4'($urandom); c4 = 4'($urandom);
      case (kind)
        0, 1, 2, 3, 4, 5, 6, 7: imem[k] = {4'(kind), a4, b4, c4};
        8:  imem[k] = {4'h8, a4, b4, 1'b0, c4[2:0]};
        9:  imem[k] = {4'h9, 12'(k + 1 + $urandom_range(3, 0))};
        default: imem[k] = {4'(10 + $urandom_range(4, 0)), a4, b4, c4};
      endcase
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int ncyc;
    for (int i = 0; i < 256; i++) dmem[i] = '0;
    clear_imem();

    // Reset state
    rst = 1'b1;
    cyc();
    cyc();
    chk("rst_imem_req", imem_req, 1'b0);
    chk("rst_dmem_req", dmem_req, 1'b0);
    chk("rst_dmem_we", dmem_we, 1'b0);
    chk("rst_state", state, 3'd0);
    chk("rst_pc", pc, 16'd0);
    chk("rst_ir", ir, 16'd0);
    chk("rst_instr_cnt", instr_cnt, 32'd0);
    chk("rst_halted", halted, 1'b0);

    // Program A: ADDI r1,r0,5; ADDI r2,r0,3; ADD r3,r1,r2; HALT
    clear_imem();
    imem[0] = 16'h5015; imem[1] = 16'h5023; imem[2] = 16'h0123; imem[3] = 16'hF000;
    do_reset();
    run_prog(200, ncyc);
    chk("A_halt_cycle", ncyc, 15);
    chk("A_instr_cnt", instr_cnt, 32'd3);
    chk_reg(1, 16'd5, "A_r1");
    chk_reg(2, 16'd3, "A_r2");
    chk_reg(3, 16'd8, "A_r3");
    chk("A_imem_req_halted", imem_req, 1'b0);

    // Program B: then SW r3,2(r0); LW r4,2(r0)
    clear_imem();
    imem[0] = 16'h5015; imem[1] = 16'h5023; imem[2] = 16'h0123;
    imem[3] = 16'h7032; imem[4] = 16'h6042; imem[5] = 16'hF000;
    do_reset();
    run_prog(200, ncyc);
    chk("B_halt_cycle", ncyc, 24);
    chk("B_instr_cnt", instr_cnt, 32'd5);
    chk("B_store_count", st_q.size(), 1);
    if (st_q.size() > 0) chk("B_store", st_q[0], {16'd2, 16'd8});
    chk("B_load_count", ld_q.size(), 1);
    if (ld_q.size() > 0) chk("B_load_addr", ld_q[0], 16'd2);
    chk_reg(4, 16'd8, "B_r4");
    if (fetch_t_q.size() > 5) begin
      chk("B_sw_latency", fetch_t_q[4] - fetch_t_q[3], 4);
      chk("B_lw_latency", fetch_t_q[5] - fetch_t_q[4], 5);
    end

    // Program C: BEQ not taken, BEQ taken at pc 4 (+2), J 0x00A
    clear_imem();
    imem[0] = 16'h5015; imem[1] = 16'h5023; imem[2] = 16'h8122; imem[3] = 16'hA000;
    imem[4] = 16'h8112; imem[7] = 16'h900A;
    do_reset();
    run_prog(200, ncyc);
    chk("C_halt_cycle", ncyc, 23);
    chk("C_instr_cnt", instr_cnt, 32'd6);
    chk("C_fetch_count", fetch_q.size(), 7);
    if (fetch_q.size() == 7) begin
      chk("C_beq_not_taken", fetch_q[3], 16'd3);
      chk("C_beq_taken", fetch_q[5], 16'd7);
      chk("C_jump", fetch_q[6], 16'd10);
      chk("C_beq_latency", fetch_t_q[5] - fetch_t_q[4], 3);
    end
    chk("C_pc_final", pc, 16'd11);

    // Program D: wait states on both memories plus edge arithmetic
    clear_imem();
    imem[0] = 16'h5051; imem[1] = 16'h1051; imem[2] = 16'h4152;
    imem[3] = 16'h5007; imem[4] = 16'h6063; imem[5] = 16'hF000;
    dmem[3] = 16'hBEEF;
    i_lo = 3; i_hi = 3; d_lo = 3; d_hi = 3;
    do_reset();
    run_prog(400, ncyc);
    chk("D_halt_cycle", ncyc, 45);
    if (fetch_t_q.size() > 5) begin
      chk("D_alu_wait_latency", fetch_t_q[1] - fetch_t_q[0], 7);
      chk("D_lw_wait_latency", fetch_t_q[5] - fetch_t_q[4], 11);
    end
    chk_reg(1, 16'hFFFF, "D_sub_wrap");
    chk_reg(2, 16'd1, "D_slt_signed");
    chk_reg(0, 16'd0, "D_r0_zero");
    chk_reg(6, 16'hBEEF, "D_lw_wait_data");

    // Program E: reset while MEM is stalled on a store
    clear_imem();
    imem[0] = 16'h5015; imem[1] = 16'h7012;
    dmem[2] = 16'h1234;
    i_lo = 0; i_hi = 0; d_lo = 20; d_hi = 20;
    do_reset();
    for (int k = 0; k < 10; k++) cyc();
    chk("E_state_mem", state, 3'd3);
    chk("E_dmem_req", dmem_req, 1'b1);
    chk("E_dmem_we", dmem_we, 1'b1);
    chk("E_dmem_addr", dmem_addr, 16'd2);
    chk("E_dmem_wdata", dmem_wdata, 16'd5);
    rst = 1'b1;
    cyc();
    chk("E_rst_dmem_req", dmem_req, 1'b0);
    chk("E_rst_state", state, 3'd0);
    chk("E_rst_pc", pc, 16'd0);
    for (int r = 0; r < 16; r++) chk_reg(r, 16'd0, $sformatf("E_rst_r%0d", r));
    rst = 1'b0;
    cyc();
    chk("E_post_dmem_req", dmem_req, 1'b0);
    chk("E_no_store", st_q.size(), 0);
    chk("E_dmem_untouched", dmem[2], 16'h1234);

    // Random programs against the ISA model with random wait states
    i_lo = 0; i_hi = 2; d_lo = 0; d_hi = 2;
    for (int t = 0; t < 4; t++) begin
      gen_prog(30);
      model_run();
      do_reset();
      run_prog(3000, ncyc);
      chk($sformatf("R%0d_cycles", t), ncyc, exp_cyc + waits);
      chk($sformatf("R%0d_instr_cnt", t), instr_cnt, 32'(exp_cnt));
      for (int r = 0; r < 16; r++) chk_reg(r, mr[r], $sformatf("R%0d_r%0d", t, r));
      chk($sformatf("R%0d_fetch_count", t), fetch_q.size(), exp_fetch_q.size());
      for (int k = 0; k < exp_fetch_q.size(); k++)
        if (k < fetch_q.size()) chk($sformatf("R%0d_fetch%0d", t, k), fetch_q[k], exp_fetch_q[k]);
      chk($sformatf("R%0d_store_count", t), st_q.size(), exp_q.size());
      for (int k = 0; k < exp_q.size(); k++)
        if (k < st_q.size()) chk($sformatf("R%0d_store%0d", t, k), st_q[k], exp_q[k]);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
